// File: rtl/iot_pkg.sv
// rtl/iot_pkg.sv - shared constants, state encoding and phase helper for the IOT sequencer
package iot_pkg;

  localparam logic [2:0] OPC_IOT = 3'o6;

  localparam int IOP1_B = 0;
  localparam int IOP2_B = 1;
  localparam int IOP4_B = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    FIN
  } state_t;

  // Lowest pending phase wins, giving the fixed IOP1 -> IOP2 -> IOP4 order.
  function automatic logic [1:0] first_phase(input logic [2:0] pend);
    if (pend[IOP1_B]) return 2'(IOP1_B);
    if (pend[IOP2_B]) return 2'(IOP2_B);
    return 2'(IOP4_B);
  endfunction

endpackage

// File: rtl/iot_sequencer_if.sv
// rtl/iot_sequencer_if.sv - control-unit / device-bus signal bundle of the IOT sequencer
interface iot_sequencer_if #(
  parameter int NUM_DEV = 8
);

  logic               start;
  logic [11:0]        ir;
  logic [NUM_DEV-1:0] dev_skip;
  logic [NUM_DEV-1:0] dev_sel;
  logic [2:0]         iop;
  logic               busy;
  logic               done;
  logic               skip;
  logic               nodev;

  modport master (
    output start, ir, dev_skip,
    input  dev_sel, iop, busy, done, skip, nodev
  );

  modport slave (
    input  start, ir, dev_skip,
    output dev_sel, iop, busy, done, skip, nodev
  );

endinterface

// File: rtl/iot_pulse_timer.sv
// rtl/iot_pulse_timer.sv - IOP strobe width counter; flags the final cycle of each pulse
module iot_pulse_timer #(
  parameter int PULSE_W = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  output logic o_last
);

  localparam int              CW     = $clog2(PULSE_W + 1);
  localparam logic [CW-1:0]   LOAD_V = CW'(PULSE_W);

  logic [CW-1:0] r_cnt;

  // Holds PULSE_W on the first strobe cycle and stops at zero, so it can never wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_V;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/iot_sequencer.sv
// rtl/iot_sequencer.sv - PDP-8 IOT execution sequencer: device window decode, timed IOP strobes,
// skip capture and busy/done handshake.
module iot_sequencer
  import iot_pkg::*;
#(
  parameter int DEV_BASE = 0,
  parameter int NUM_DEV  = 8,
  parameter int PULSE_W  = 2
) (
  input logic            i_clk,
  input logic            i_rst_n,
  iot_sequencer_if.slave bus
);

  localparam logic [6:0] W_LO  = 7'(DEV_BASE);
  localparam logic [6:0] W_NUM = 7'(NUM_DEV);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_DEV-1:0] r_sel;
  logic [2:0]         r_pend;
  logic [1:0]         r_phase;
  logic               r_skip;
  logic               r_nodev;

  logic [6:0]         w_off;
  logic               w_hit;
  logic [NUM_DEV-1:0] w_onehot;
  logic               w_accept;
  logic               w_load;
  logic               w_last;
  logic [1:0]         w_first;

  // A code below the base wraps to >= 65 in 7 bits, so one compare covers both window edges.
  assign w_off = {1'b0, bus.ir[8:3]} - W_LO;
  assign w_hit = (bus.ir[11:9] == OPC_IOT) && (w_off < W_NUM);

  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      w_onehot[k] = (w_off == 7'(k));
    end
  end

  assign w_first = first_phase(r_pend);

  iot_pulse_timer #(
    .PULSE_W (PULSE_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_hit ? SETUP : FIN;
        end
      end
      SETUP, HOLD: begin
        if (r_pend == 3'b000) begin
          w_state_nxt = FIN;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = PULSE;
        end
      end
      PULSE: begin
        if (w_last) begin
          w_state_nxt = HOLD;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel   <= '0;
      r_pend  <= 3'b000;
      r_phase <= 2'd0;
      r_skip  <= 1'b0;
      r_nodev <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sel   <= w_hit ? w_onehot : '0;
        r_pend  <= w_hit ? bus.ir[2:0] : 3'b000;
        r_skip  <= 1'b0;
        r_nodev <= !w_hit;
      end
      if (w_load) begin
        r_phase <= w_first;
        r_pend  <= r_pend & ~(3'b001 << w_first);
      end
      if (r_state == PULSE && w_last) begin
        r_skip <= r_skip | (|(bus.dev_skip & r_sel));
      end
      if (r_state == FIN) begin
        r_sel <= '0;
      end
    end
  end

  assign bus.dev_sel = r_sel;
  assign bus.iop     = (r_state == PULSE) ? (3'b001 << r_phase) : 3'b000;
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = (r_state == FIN);
  assign bus.skip    = r_skip;
  assign bus.nodev   = r_nodev;

endmodule

// File: doc/iot_sequencer.md
Name: iot_sequencer

Overview:
Parametrised IOT (opcode 6) execution sequencer for the PDP-8 core. It decodes the 6-bit device code IR[8:3] against a configurable contiguous device window and drives a one-hot device select. It then issues the IOP1/IOP2/IOP4 strobes in order, one for each set bit of IR[0..2], each with a programmable width. It also collects device skip requests and reports completion to the control unit. It is the timed successor to the purely combinational IOT decode: any device window, real pulse timing, skip capture and a busy/done handshake.

Parameters:
DEV_BASE, 0, first device code (0..63) owned by this sequencer.
NUM_DEV, 8, number of consecutive device codes decoded (1..64; DEV_BASE+NUM_DEV <= 64).
PULSE_W, 2, IOP strobe width in clock cycles (>= 1).

Ports:
CLK  in  1  system clock, rising edge.
RESET_N  in  1  asynchronous active-low reset.
START  in  1  one-cycle request to execute the IOT held in IR; honoured only in IDLE.
IR  in  12  instruction register; sampled on the accepted START.
DEV_SKIP  in  NUM_DEV  per-device skip request, indexed by (devcode - DEV_BASE).
DEV_SEL  out  NUM_DEV  one-hot selected device; all-zero when no device is selected.
IOP  out  3  bit0 = IOP1, bit1 = IOP2, bit2 = IOP4; at most one bit high at a time.
BUSY  out  1  high while a sequence is in progress.
DONE  out  1  one-cycle completion pulse.
SKIP  out  1  OR of skip samples for the last sequence; valid from DONE until the next accepted START.
NODEV  out  1  last sequence hit no device (bad opcode or code outside the window); valid like SKIP.

Behaviour:
- Reset (async, RESET_N = 0): state IDLE; DEV_SEL, IOP, BUSY, DONE, SKIP and NODEV all 0; latched IR cleared. The reset takes effect immediately, including mid-sequence; strobes drop without finishing.
- States: IDLE, SETUP, PULSE, HOLD, FIN.
- IDLE: when START = 1, latch IR, clear SKIP and NODEV, and set BUSY the next cycle.
  - If IR[11:9] != 3'o6 or the device code is outside [DEV_BASE, DEV_BASE+NUM_DEV): go to FIN and set NODEV. DEV_SEL stays 0 and no IOP is issued.
  - Otherwise go to SETUP.
- SETUP (1 cycle): DEV_SEL[dev - DEV_BASE] = 1. DEV_SEL then stays stable through FIN inclusive.
- Phase order is IOP1, IOP2, IOP4. Phases whose IR bit (IR[0], IR[1], IR[2] respectively) is 0 take zero cycles.
- PULSE: the selected IOP bit is high for exactly PULSE_W cycles.
  - DEV_SKIP[sel] is sampled on the last cycle of the pulse and ORed into SKIP.
- HOLD (1 cycle): IOP = 0, DEV_SEL held. Then go to the next enabled phase, or to FIN if none remains.
- If IR[2:0] = 000: go from SETUP directly to FIN.
- FIN (1 cycle): DONE = 1, BUSY = 1. Next cycle: IDLE, BUSY = 0, DEV_SEL = 0.
- START while BUSY (including the FIN cycle) is ignored. No queueing.
- Latency from the START edge (t0), valid device:
  - DONE at t0 + 2 + n*(PULSE_W+1), where n = popcount(IR[2:0]).
  - NODEV case: DONE at t0 + 1.
- IR changes after START have no effect. DEV_SKIP changes outside the sample cycles have no effect.
- A phase counter of width clog2(PULSE_W+1) saturates or reloads; it must never wrap mid-pulse.

Decomposition:
- Shared package iot_pkg:
  - constant OPC_IOT = 3'o6
  - state enum {IDLE, SETUP, PULSE, HOLD, FIN}
  - IOP bit indices IOP1_B = 0, IOP2_B = 1, IOP4_B = 2
- One natural sub-module: iot_pulse_timer. It loads PULSE_W, counts down, and flags the last cycle of a pulse. The top level holds the FSM, device-window compare, one-hot select and skip accumulation.

Test Plan:
1. Defaults; IR = 6'o6032 (dev 03, IOP2 only); START at t0 -> DEV_SEL = 8'b0000_1000 from t1 to t5; IOP = 3'b010 on t2–t3; DONE at t5; NODEV = 0; SKIP = 0.
2. IR = 6'o6047 (dev 04, all phases); DEV_SKIP[4] high only during t5–t6 -> IOP1 t2–3, IOP2 t5–6, IOP4 t8–9; DONE at t11; SKIP = 1.
3. DEV_BASE = 16, NUM_DEV = 8; IR = 6'o6221 (dev 22o = 18) -> DEV_SEL[2] = 1. IR = 6'o6011 -> DONE at t1, NODEV = 1, DEV_SEL = 0, IOP = 0.
4. IR = 6'o6030 -> DONE at t2, no IOP strobe. IR = 6'o7000 -> NODEV = 1 at t1.
5. START re-pulsed during PULSE and during FIN -> ignored; exactly one DONE per accepted START. START in the cycle after FIN -> accepted.
6. RESET_N low mid-IOP2 (async, between edges) -> IOP, DEV_SEL, BUSY and SKIP go to 0 immediately. After release, the next START runs a full normal sequence.
